// File: rtl/i2c_slave_responder.sv
// I2C slave: oversamples SCL/SDA on the core clock, matches a 7-bit address,
// delivers written bytes to a local byte port and returns local bytes on reads.
module i2c_slave_responder #(
  parameter logic [6:0] SLAVE_ADDR = 7'b0100_101
) (
  input  logic       i2c_core_clk_i,
  input  logic       preset_ni,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_oe_o,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  input  logic       rx_ack_en_i,
  input  logic [7:0] tx_data_i,
  output logic       tx_ld_o,
  output logic       busy_o,
  output logic       rw_o
);

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, IGNORE
  } state_t;

  state_t      state;
  logic [2:0]  bit_cnt;
  logic        byte_done;
  logic [7:0]  shreg;

  logic scl_p0, scl_p1, scl_p2;
  logic sda_p0, sda_p1, sda_p2;

  // Two-flop synchronizers (_p0/_p1) plus previous value (_p2); idle bus is high.
  always_ff @(posedge i2c_core_clk_i or negedge preset_ni) begin
    if (!preset_ni) begin
      scl_p0 <= 1'b1;
      scl_p1 <= 1'b1;
      scl_p2 <= 1'b1;
      sda_p0 <= 1'b1;
      sda_p1 <= 1'b1;
      sda_p2 <= 1'b1;
    end else begin
      scl_p0 <= scl_i;
      scl_p1 <= scl_p0;
      scl_p2 <= scl_p1;
      sda_p0 <= sda_i;
      sda_p1 <= sda_p0;
      sda_p2 <= sda_p1;
    end
  end

  logic scl_rise, scl_fall, start_evt, stop_evt;

  assign scl_rise  = scl_p1 & ~scl_p2;
  assign scl_fall  = ~scl_p1 & scl_p2;
  assign start_evt = scl_p1 & scl_p2 & sda_p2 & ~sda_p1;
  assign stop_evt  = scl_p1 & scl_p2 & ~sda_p2 & sda_p1;

  always_ff @(posedge i2c_core_clk_i or negedge preset_ni) begin
    if (!preset_ni) begin
      state      <= IDLE;
      bit_cnt    <= 3'd7;
      byte_done  <= 1'b0;
      shreg      <= 8'h00;
      sda_oe_o   <= 1'b0;
      rx_data_o  <= 8'h00;
      rx_valid_o <= 1'b0;
      tx_ld_o    <= 1'b0;
      busy_o     <= 1'b0;
      rw_o       <= 1'b0;
    end else begin
      rx_valid_o <= 1'b0;
      tx_ld_o    <= 1'b0;
      if (start_evt) begin
        state     <= ADDR;
        bit_cnt   <= 3'd7;
        byte_done <= 1'b0;
        sda_oe_o  <= 1'b0;
        busy_o    <= 1'b0;
      end else if (stop_evt) begin
        state    <= IDLE;
        sda_oe_o <= 1'b0;
        busy_o   <= 1'b0;
      end else begin
        case (state)
          ADDR, WR_BYTE: begin
            // byte_done holds off the fall-edge decision until bit 0 is in.
            if (scl_rise && !byte_done) begin
              shreg <= {shreg[6:0], sda_p1};
              if (bit_cnt == 3'd0) byte_done <= 1'b1;
              else                 bit_cnt   <= bit_cnt - 3'd1;
            end else if (scl_fall && byte_done) begin
              if (state == ADDR) begin
                if (shreg[7:1] == SLAVE_ADDR) begin
                  rw_o     <= shreg[0];
                  sda_oe_o <= 1'b1;
                  busy_o   <= 1'b1;
                  state    <= ADDR_ACK;
                end else begin
                  sda_oe_o <= 1'b0;
                  state    <= IGNORE;
                end
              end else begin
                rx_data_o  <= shreg;
                rx_valid_o <= 1'b1;
                sda_oe_o   <= rx_ack_en_i;
                state      <= WR_ACK;
              end
            end
          end
          ADDR_ACK: begin
            if (scl_fall) begin
              if (!rw_o) begin
                sda_oe_o  <= 1'b0;
                bit_cnt   <= 3'd7;
                byte_done <= 1'b0;
                state     <= WR_BYTE;
              end else begin
                tx_ld_o  <= 1'b1;
                shreg    <= tx_data_i;
                sda_oe_o <= ~tx_data_i[7];
                bit_cnt  <= 3'd7;
                state    <= RD_BYTE;
              end
            end
          end
          WR_ACK: begin
            if (scl_fall) begin
              sda_oe_o  <= 1'b0;
              bit_cnt   <= 3'd7;
              byte_done <= 1'b0;
              state     <= WR_BYTE;
            end
          end
          RD_BYTE: begin
            // bit_cnt tracks the bit currently on the bus; the MSB leads shreg.
            if (scl_fall) begin
              if (bit_cnt == 3'd0) begin
                sda_oe_o <= 1'b0;
                state    <= RD_ACK;
              end else begin
                bit_cnt  <= bit_cnt - 3'd1;
                shreg    <= {shreg[6:0], 1'b0};
                sda_oe_o <= ~shreg[6];
              end
            end
          end
          RD_ACK: begin
            if (scl_rise && sda_p1) begin
              sda_oe_o <= 1'b0;
              state    <= IGNORE;
            end else if (scl_fall) begin
              tx_ld_o  <= 1'b1;
              shreg    <= tx_data_i;
              sda_oe_o <= ~tx_data_i[7];
              bit_cnt  <= 3'd7;
              state    <= RD_BYTE;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_slave_responder.sv
// Directed bench: a bit-banged I2C master drives the responder through writes,
// reads, address mismatch, repeated START, and mid-transfer disruptions.
module tb_i2c_slave_responder;

  localparam time Q = 40;

  logic       clk = 1'b0;
  logic       preset_ni;
  logic       scl_m, sda_m, sda_bus;
  logic       sda_oe, rx_valid, tx_ld, busy, rw;
  logic       rx_ack_en;
  logic [7:0] rx_data, tx_data;

  int n_cmp = 0;
  int n_err = 0;
  int rx_cnt = 0, tx_cnt = 0, oe_cnt = 0, both_cnt = 0;
  logic [7:0] rx_log [0:31];

  always #5 clk = ~clk;

  assign sda_bus = sda_m & ~sda_oe;

  i2c_slave_responder #(.SLAVE_ADDR(7'b0100_101)) dut (
    .i2c_core_clk_i(clk),
    .preset_ni     (preset_ni),
    .scl_i         (scl_m),
    .sda_i         (sda_bus),
    .sda_oe_o      (sda_oe),
    .rx_data_o     (rx_data),
    .rx_valid_o    (rx_valid),
    .rx_ack_en_i   (rx_ack_en),
    .tx_data_i     (tx_data),
    .tx_ld_o       (tx_ld),
    .busy_o        (busy),
    .rw_o          (rw)
  );

  always @(negedge clk) begin
    if (rx_valid) begin
      rx_log[rx_cnt[4:0]] <= rx_data;
      rx_cnt <= rx_cnt + 1;
    end
    if (tx_ld) tx_cnt <= tx_cnt + 1;
    if (sda_oe) oe_cnt <= oe_cnt + 1;
    if (rx_valid && tx_ld) both_cnt <= both_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic bus_start();
    if (scl_m == 1'b0) begin
      #Q sda_m = 1'b1;
      #Q scl_m = 1'b1;
    end
    #Q sda_m = 1'b0;
    #Q scl_m = 1'b0;
  endtask

  task automatic bus_stop();
    #Q sda_m = 1'b0;
    #Q scl_m = 1'b1;
    #Q sda_m = 1'b1;
    #Q;
  endtask

  task automatic bit_xfer(input logic b, output logic r);
    #Q sda_m = b;
    #Q scl_m = 1'b1;
    #Q r = sda_bus;
    #Q scl_m = 1'b0;
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) bit_xfer(b[i], r);
    bit_xfer(1'b1, ack);
  endtask

  task automatic read_byte(output logic [7:0] b);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      bit_xfer(1'b1, r);
      b[i] = r;
    end
  endtask

  initial begin
    logic       a, d;
    logic [7:0] b1, b2, v;
    int         r0, t0, o0;

    preset_ni = 1'b0;
    scl_m = 1'b1;
    sda_m = 1'b1;
    rx_ack_en = 1'b1;
    tx_data = 8'h00;
    #100;
    chk("rst_sda_oe", sda_oe, 0);
    chk("rst_rx_data", rx_data, 0);
    chk("rst_rx_valid", rx_valid, 0);
    chk("rst_tx_ld", tx_ld, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rw", rw, 0);
    preset_ni = 1'b1;
    #100;

    // master write of three bytes
    r0 = rx_cnt;
    bus_start();
    write_byte(8'h4A, a); chk("wr_addr_ack", a, 0);
    chk("wr_busy", busy, 1);
    chk("wr_rw", rw, 0);
    write_byte(8'h8A, a); chk("wr_ack1", a, 0);
    write_byte(8'h2B, a); chk("wr_ack2", a, 0);
    write_byte(8'hC3, a); chk("wr_ack3", a, 0);
    bus_stop();
    #100;
    chk("wr_rx_count", rx_cnt - r0, 3);
    chk("wr_rx0", rx_log[r0[4:0]], 8'h8A);
    chk("wr_rx1", rx_log[5'(r0 + 1)], 8'h2B);
    chk("wr_rx2", rx_log[5'(r0 + 2)], 8'hC3);
    chk("wr_busy_after_stop", busy, 0);
    chk("wr_oe_after_stop", sda_oe, 0);

    // address mismatch
    r0 = rx_cnt;
    o0 = oe_cnt;
    bus_start();
    write_byte(8'h69, a); chk("mm_addr_nack", a, 1);
    chk("mm_busy", busy, 0);
    write_byte(8'h11, a); chk("mm_data_nack", a, 1);
    bus_stop();
    #100;
    chk("mm_oe_cycles", oe_cnt - o0, 0);
    chk("mm_rx_count", rx_cnt - r0, 0);

    // master read of two bytes, ACK then NACK
    tx_data = 8'h94;
    t0 = tx_cnt;
    bus_start();
    write_byte(8'h4B, a); chk("rd_addr_ack", a, 0);
    chk("rd_rw", rw, 1);
    read_byte(b1);
    tx_data = 8'hC5;
    bit_xfer(1'b0, d);
    read_byte(b2);
    bit_xfer(1'b1, a); chk("rd_released_in_nack", a, 1);
    bus_stop();
    #100;
    chk("rd_byte1", b1, 8'h94);
    chk("rd_byte2", b2, 8'hC5);
    chk("rd_tx_ld_count", tx_cnt - t0, 2);
    chk("rd_oe_after", sda_oe, 0);

    // data bytes NACKed when rx_ack_en is low
    rx_ack_en = 1'b0;
    r0 = rx_cnt;
    bus_start();
    write_byte(8'h4A, a); chk("na_addr_ack", a, 0);
    write_byte(8'h55, a); chk("na_data_nack", a, 1);
    bus_stop();
    #100;
    rx_ack_en = 1'b1;
    chk("na_rx_count", rx_cnt - r0, 1);
    chk("na_rx_data", rx_log[r0[4:0]], 8'h55);

    // repeated START: write then read
    tx_data = 8'h3C;
    bus_start();
    write_byte(8'h4A, a); chk("sr_wr_addr_ack", a, 0);
    chk("sr_rw_write", rw, 0);
    write_byte(8'h01, a); chk("sr_wr_ack", a, 0);
    bus_start();
    write_byte(8'h4B, a); chk("sr_rd_addr_ack", a, 0);
    chk("sr_rw_read", rw, 1);
    read_byte(b1);
    bit_xfer(1'b1, a);
    bus_stop();
    #100;
    chk("sr_rx_data", rx_data, 8'h01);
    chk("sr_rd_byte", b1, 8'h3C);

    // STOP after four data bits discards the partial byte
    r0 = rx_cnt;
    bus_start();
    write_byte(8'h4A, a); chk("ds_addr_ack", a, 0);
    bit_xfer(1'b1, d);
    bit_xfer(1'b0, d);
    bit_xfer(1'b1, d);
    bit_xfer(1'b0, d);
    bus_stop();
    #100;
    chk("ds_rx_count", rx_cnt - r0, 0);
    chk("ds_busy", busy, 0);
    chk("ds_oe", sda_oe, 0);

    // reset asserted while the slave drives the address ACK
    v = 8'h4A;
    bus_start();
    for (int i = 7; i >= 0; i--) bit_xfer(v[i], d);
    #60;
    chk("rs_oe_before", sda_oe, 1);
    preset_ni = 1'b0;
    #1;
    chk("rs_oe", sda_oe, 0);
    chk("rs_rx_data", rx_data, 0);
    chk("rs_rx_valid", rx_valid, 0);
    chk("rs_tx_ld", tx_ld, 0);
    chk("rs_busy", busy, 0);
    chk("rs_rw", rw, 0);
    #9;
    preset_ni = 1'b1;
    #100;
    bus_stop();
    #100;
    chk("rs_oe_idle", sda_oe, 0);
    chk("rs_busy_idle", busy, 0);
    chk("no_rx_tx_overlap", both_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/i2c_slave_responder.md
Name: i2c_slave_responder

Overview:
Synthesizable I2C slave that sits on the far side of the sda/scl bus driven by i2c_top. It is the consumer of every transaction the master core issues. It oversamples SCL/SDA on its core clock and detects START/STOP. It matches a 7-bit address, ACKs and delivers written bytes to a local byte interface, and shifts out local bytes on master reads. It is used as the bus-level DUT partner in i2c_top regression and as a reusable on-chip slave.

Parameters:
SLAVE_ADDR, 7'b0100_101, 7-bit address this slave responds to (general call not supported)

Ports:
i2c_core_clk_i  input  1  core clock; all logic on rising edge
preset_ni  input  1  reset, asynchronous assert, active-low
scl_i  input  1  bus SCL (pin level, asynchronous)
sda_i  input  1  bus SDA (pin level, asynchronous)
sda_oe_o  output  1  1 = pull SDA low (open drain); 0 = release
rx_data_o  output  8  last byte written by master
rx_valid_o  output  1  one-cycle pulse: rx_data_o updated
rx_ack_en_i  input  1  1 = ACK written data bytes; 0 = NACK them (address ACK unaffected)
tx_data_i  input  8  byte to return on master read
tx_ld_o  output  1  one-cycle pulse: tx_data_i captured this cycle; the local side may present the next byte
busy_o  output  1  high from matched address ACK until STOP/START
rw_o  output  1  R/W bit of the current matched transaction (1 = read)

Behaviour:
- Clock and reset: one clock, i2c_core_clk_i. preset_ni is asynchronous, active-low. Reset values: sda_oe_o=0, rx_data_o=0, rx_valid_o=0, tx_ld_o=0, busy_o=0, rw_o=0, state=IDLE.
- Input conditioning: scl_i and sda_i each pass through a 2-flop synchronizer plus a registered previous value for edge detect. Internal events lag pin edges by 3 clocks.
- Bus timing requirement: SCL high and low phases are each >= 4 core clocks.
- Bus events:
  - START = SDA fall while SCL high. STOP = SDA rise while SCL high.
  - Data is sampled on SCL rise. sda_oe_o changes only on SCL fall.
- States: IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, IGNORE.
- START from any state: go to ADDR, bit counter=7, sda_oe_o=0, busy_o=0. This covers repeated START.
- STOP from any state: go to IDLE, sda_oe_o=0, busy_o=0.
- ADDR: shift 8 bits MSB first. At the SCL fall after bit 0:
  - Address match: latch rw_o, set sda_oe_o=1, busy_o=1, go to ADDR_ACK.
  - Mismatch: go to IGNORE with SDA released. IGNORE exits only on START/STOP.
- ADDR_ACK, at the next SCL fall:
  - rw_o=0: release SDA, go to WR_BYTE.
  - rw_o=1: pulse tx_ld_o, load tx_data_i into the shift register, drive bit7 (sda_oe_o = ~bit), go to RD_BYTE.
- WR_BYTE: sample 8 bits. At the SCL fall after the 8th bit:
  - rx_data_o <= byte and rx_valid_o pulses for 1 cycle.
  - sda_oe_o <= rx_ack_en_i; go to WR_ACK.
- WR_ACK: at the next SCL fall, release SDA and return to WR_BYTE with counter=7.
- RD_BYTE: at each SCL fall drive the next bit. At the SCL fall after the 8th bit, release SDA and go to RD_ACK.
- RD_ACK: sample SDA on SCL rise.
  - 0 (ACK): at the following SCL fall, pulse tx_ld_o, load tx_data_i, drive bit7, go to RD_BYTE.
  - 1 (NACK): go to IGNORE with SDA released.
- Bit counter wraps 0 -> 7 only via state transitions. Partial bytes cut by START/STOP are discarded (no rx_valid_o).
- rx_valid_o and tx_ld_o are never asserted in the same cycle.
- Reset mid-transfer releases SDA immediately (asynchronous). After reset the slave stays in IDLE until the next START.

Test Plan:
- Master write: START, 0x4A (addr 0x25, W), 0x8A, 0x2B, 0xC3, STOP -> SDA low in all 4 ACK slots; rx_valid_o pulses 3x with rx_data_o = 0x8A, 0x2B, 0xC3; busy_o low after STOP.
- Address mismatch: START, 0x69, 0x11 -> sda_oe_o stays 0 throughout; no rx_valid_o; busy_o stays 0.
- Master read: START, 0x4B; tx_data_i = 0x94 then 0xC5 after the first tx_ld_o; master ACKs byte 1 and NACKs byte 2 -> SDA bits 10010100 then 11000101; exactly 2 tx_ld_o pulses; SDA released after byte 2.
- rx_ack_en_i=0 during write of 0x4A, 0x55 -> address ACKed; data slot reads SDA=1; rx_valid_o still pulses with 0x55.
- Repeated START: write 0x4A, 0x01, then Sr, 0x4B, read 1 byte -> rw_o switches 0 -> 1; rx_data_o = 0x01; the read returns tx_data_i.
- Disruptions: STOP after 4 bits of a data byte -> no rx_valid_o, state IDLE. preset_ni low while driving an ACK -> sda_oe_o=0 within the same cycle; all outputs at reset values.
